// File: rtl/hilo_pipe_pkg.sv
// Shared constants for the HI/LO pipeline: select-bit positions and reset defaults.
package hilo_pipe_pkg;

   // Width of the {HI,LO} pair and of each half
   localparam int unsigned HILO_W_DEF = 64;
   localparam int unsigned HALF_W_DEF = HILO_W_DEF / 2;

   // hilo_selectE bit positions
   localparam int unsigned SEL_MFHILO = 1;   // 1 = MFHI/MFLO instruction in E
   localparam int unsigned SEL_HI     = 0;   // 1 = read HI, 0 = read LO

   // Default reset values of the architectural halves
   localparam logic [HALF_W_DEF-1:0] RST_HI_DEF = 32'h0;
   localparam logic [HALF_W_DEF-1:0] RST_LO_DEF = 32'h0;

endpackage : hilo_pipe_pkg

// File: rtl/hilo_stage_reg.sv
// Valid + data pipeline register with flush / stall / bubble control.
// Priority: flush_i (kill) > stall_i (hold) > bubble_i (insert empty slot) > capture.
// Ports:
//   clk, rst        : clock, async active-low reset
//   flush_i         : clear valid
//   stall_i         : hold valid and data
//   bubble_i        : clear valid (upstream stage held)
//   valid_i, data_i : incoming write
//   valid_o, data_o : registered write
module hilo_stage_reg #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         stall_i,
   input  logic         bubble_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;

   // Next-state selection; data is only replaced on a real capture
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (stall_i) begin
         valid_d = valid_q;
      end else if (bubble_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_i;
         data_d  = data_i;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : hilo_stage_reg

// File: rtl/hilo_pipe.sv
// Architectural HI/LO register with its E->M->W pending-write pipeline.
// Writes commit at W so an instruction killed in M never updates HI/LO;
// the youngest in-flight write is forwarded back to the E-stage ALU.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   stallE/M/W               : per-stage hold
//   flushM, flushW           : kill instruction entering M / W
//   hilo_wenE, hilo_selectE  : E-stage write enable and MFHI/MFLO select
//   aluoutE                  : new {HI,LO} from the ALU
//   hilo_fwdE                : forwarded {HI,LO} for E (combinational)
//   mfhilo_dataE             : MFHI/MFLO read half (combinational)
//   hilo_o                   : committed {HI,LO}
//   hilo_busy                : a write is in flight in M or W
module hilo_pipe
   import hilo_pipe_pkg::*;
#(
   parameter int unsigned HILO_W = HILO_W_DEF,
   parameter logic [31:0] RST_HI = RST_HI_DEF,
   parameter logic [31:0] RST_LO = RST_LO_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallE,
   input  logic              stallM,
   input  logic              stallW,
   input  logic              flushM,
   input  logic              flushW,
   input  logic              hilo_wenE,
   input  logic [1:0]        hilo_selectE,
   input  logic [HILO_W-1:0] aluoutE,
   output logic [HILO_W-1:0] hilo_fwdE,
   output logic [HILO_W/2-1:0] mfhilo_dataE,
   output logic [HILO_W-1:0] hilo_o,
   output logic              hilo_busy
);

   localparam int unsigned HALF_W = HILO_W / 2;
   localparam logic [HILO_W-1:0] RST_HILO = {HALF_W'(RST_HI), HALF_W'(RST_LO)};

   logic              valid_m, valid_w;
   logic [HILO_W-1:0] data_m,  data_w;
   logic [HILO_W-1:0] hilo_q,  hilo_d;

   // E->M: stallE with M free turns the slot into a bubble
   hilo_stage_reg #(.W(HILO_W)) u_stage_m (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flushM),
      .stall_i  (stallM),
      .bubble_i (stallE),
      .valid_i  (hilo_wenE),
      .data_i   (aluoutE),
      .valid_o  (valid_m),
      .data_o   (data_m)
   );

   // M->W: stallM with W free turns the slot into a bubble
   hilo_stage_reg #(.W(HILO_W)) u_stage_w (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flushW),
      .stall_i  (stallW),
      .bubble_i (stallM),
      .valid_i  (valid_m),
      .data_i   (data_m),
      .valid_o  (valid_w),
      .data_o   (data_w)
   );

   // Commit: flushes only affect younger instructions, never the one already in W
   always_comb begin
      hilo_d = hilo_q;
      if (valid_w && !stallW) begin
         hilo_d = data_w;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hilo_q <= RST_HILO;
      end else begin
         hilo_q <= hilo_d;
      end
   end

   // Forwarding, youngest pending write first
   always_comb begin
      hilo_fwdE = hilo_q;
      if (valid_m) begin
         hilo_fwdE = data_m;
      end else if (valid_w) begin
         hilo_fwdE = data_w;
      end
   end

   // MFHI/MFLO half select; zero when E is not a move-from
   always_comb begin
      mfhilo_dataE = '0;
      if (hilo_selectE[SEL_MFHILO]) begin
         if (hilo_selectE[SEL_HI]) begin
            mfhilo_dataE = hilo_fwdE[HILO_W-1 -: HALF_W];
         end else begin
            mfhilo_dataE = hilo_fwdE[HALF_W-1:0];
         end
      end
   end

   assign hilo_o    = hilo_q;
   assign hilo_busy = valid_m | valid_w;

endmodule : hilo_pipe

// File: tb/tb_hilo_pipe.sv
// Directed self-checking bench for hilo_pipe.
module tb_hilo_pipe;

   logic        clk;
   logic        rst;
   logic        stallE, stallM, stallW, flushM, flushW;
   logic        hilo_wenE;
   logic [1:0]  hilo_selectE;
   logic [63:0] aluoutE;
   logic [63:0] hilo_fwdE;
   logic [31:0] mfhilo_dataE;
   logic [63:0] hilo_o;
   logic        hilo_busy;

   int n_cmp;
   int n_err;

   hilo_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .stallE       (stallE),
      .stallM       (stallM),
      .stallW       (stallW),
      .flushM       (flushM),
      .flushW       (flushW),
      .hilo_wenE    (hilo_wenE),
      .hilo_selectE (hilo_selectE),
      .aluoutE      (aluoutE),
      .hilo_fwdE    (hilo_fwdE),
      .mfhilo_dataE (mfhilo_dataE),
      .hilo_o       (hilo_o),
      .hilo_busy    (hilo_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      stallE = 0; stallM = 0; stallW = 0; flushM = 0; flushW = 0;
      hilo_wenE = 0; hilo_selectE = 2'b00; aluoutE = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #3;
      n_cmp++; if (hilo_o !== 64'h0) begin n_err++; $display("FAIL reset_hilo_o: got %h want %h", hilo_o, 64'h0); end
      n_cmp++; if (hilo_fwdE !== 64'h0) begin n_err++; $display("FAIL reset_fwd: got %h want %h", hilo_fwdE, 64'h0); end
      n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", hilo_busy); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_mthi();
      hilo_wenE = 1; aluoutE = 64'h12345678_00000000;
      tick();
      hilo_wenE = 0; aluoutE = '0; hilo_selectE = 2'b11;
      #1;
      n_cmp++; if (hilo_fwdE !== 64'h12345678_00000000) begin n_err++; $display("FAIL mthi_fwd1: got %h want %h", hilo_fwdE, 64'h12345678_00000000); end
      n_cmp++; if (hilo_busy !== 1'b1) begin n_err++; $display("FAIL mthi_busy: got %b want 1", hilo_busy); end
      n_cmp++; if (hilo_o !== 64'h0) begin n_err++; $display("FAIL mthi_o1: got %h want %h", hilo_o, 64'h0); end
      n_cmp++; if (mfhilo_dataE !== 32'h12345678) begin n_err++; $display("FAIL mthi_mfhi: got %h want %h", mfhilo_dataE, 32'h12345678); end
      hilo_selectE = 2'b10; #1;
      n_cmp++; if (mfhilo_dataE !== 32'h0) begin n_err++; $display("FAIL mthi_mflo: got %h want %h", mfhilo_dataE, 32'h0); end
      hilo_selectE = 2'b01; #1;
      n_cmp++; if (mfhilo_dataE !== 32'h0) begin n_err++; $display("FAIL mthi_nomf: got %h want %h", mfhilo_dataE, 32'h0); end
      hilo_selectE = 2'b00;
      tick();
      n_cmp++; if (hilo_o !== 64'h0) begin n_err++; $display("FAIL mthi_o2: got %h want %h", hilo_o, 64'h0); end
      n_cmp++; if (hilo_fwdE !== 64'h12345678_00000000) begin n_err++; $display("FAIL mthi_fwd2: got %h want %h", hilo_fwdE, 64'h12345678_00000000); end
      tick();
      n_cmp++; if (hilo_o !== 64'h12345678_00000000) begin n_err++; $display("FAIL mthi_o3: got %h want %h", hilo_o, 64'h12345678_00000000); end
      n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy3: got %b want 0", hilo_busy); end
   endtask

   task automatic test_back_to_back();
      hilo_wenE = 1; aluoutE = 64'h1;
      tick();
      n_cmp++; if (hilo_fwdE !== 64'h1) begin n_err++; $display("FAIL b2b_fwdA: got %h want %h", hilo_fwdE, 64'h1); end
      aluoutE = 64'h2;
      tick();
      hilo_wenE = 0; aluoutE = '0;
      n_cmp++; if (hilo_fwdE !== 64'h2) begin n_err++; $display("FAIL b2b_fwdB: got %h want %h", hilo_fwdE, 64'h2); end
      tick();
      n_cmp++; if (hilo_o !== 64'h1) begin n_err++; $display("FAIL b2b_oA: got %h want %h", hilo_o, 64'h1); end
      n_cmp++; if (hilo_fwdE !== 64'h2) begin n_err++; $display("FAIL b2b_fwdW: got %h want %h", hilo_fwdE, 64'h2); end
      tick();
      n_cmp++; if (hilo_o !== 64'h2) begin n_err++; $display("FAIL b2b_oB: got %h want %h", hilo_o, 64'h2); end
      tick();
      n_cmp++; if (hilo_o !== 64'h2) begin n_err++; $display("FAIL b2b_hold: got %h want %h", hilo_o, 64'h2); end
   endtask

   task automatic test_exception();
      hilo_wenE = 1; aluoutE = 64'hDEAD;
      tick();
      hilo_wenE = 0; aluoutE = '0;
      n_cmp++; if (hilo_fwdE !== 64'hDEAD) begin n_err++; $display("FAIL exc_fwdM: got %h want %h", hilo_fwdE, 64'hDEAD); end
      flushW = 1;
      tick();
      flushW = 0;
      n_cmp++; if (hilo_fwdE !== 64'h2) begin n_err++; $display("FAIL exc_fwd: got %h want %h", hilo_fwdE, 64'h2); end
      n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL exc_busy: got %b want 0", hilo_busy); end
      tick();
      n_cmp++; if (hilo_o !== 64'h2) begin n_err++; $display("FAIL exc_o: got %h want %h", hilo_o, 64'h2); end
   endtask

   task automatic test_stalls();
      stallE = 1; hilo_wenE = 1; aluoutE = 64'hFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL stallE_busy%0d: got %b want 0", i, hilo_busy); end
      end
      stallE = 0; aluoutE = 64'hAB;
      tick();
      hilo_wenE = 0; aluoutE = '0;
      n_cmp++; if (hilo_fwdE !== 64'hAB) begin n_err++; $display("FAIL stallE_fwd: got %h want %h", hilo_fwdE, 64'hAB); end
      tick();
      n_cmp++; if (hilo_o !== 64'h2) begin n_err++; $display("FAIL stallW_pre: got %h want %h", hilo_o, 64'h2); end
      stallW = 1;
      tick();
      n_cmp++; if (hilo_o !== 64'h2) begin n_err++; $display("FAIL stallW_1: got %h want %h", hilo_o, 64'h2); end
      tick();
      n_cmp++; if (hilo_o !== 64'h2) begin n_err++; $display("FAIL stallW_2: got %h want %h", hilo_o, 64'h2); end
      n_cmp++; if (hilo_fwdE !== 64'hAB) begin n_err++; $display("FAIL stallW_fwd: got %h want %h", hilo_fwdE, 64'hAB); end
      stallW = 0;
      tick();
      n_cmp++; if (hilo_o !== 64'hAB) begin n_err++; $display("FAIL stallW_commit: got %h want %h", hilo_o, 64'hAB); end
      n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL stallW_busy: got %b want 0", hilo_busy); end
   endtask

   task automatic test_flush_stall();
      hilo_wenE = 1; aluoutE = 64'h55;
      tick();
      aluoutE = 64'h66;
      tick();
      hilo_wenE = 0; aluoutE = '0;
      flushM = 1; stallM = 1;
      tick();
      flushM = 0; stallM = 0;
      n_cmp++; if (hilo_o !== 64'h55) begin n_err++; $display("FAIL fm_commit: got %h want %h", hilo_o, 64'h55); end
      n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL fm_busy: got %b want 0", hilo_busy); end
      n_cmp++; if (hilo_fwdE !== 64'h55) begin n_err++; $display("FAIL fm_fwd: got %h want %h", hilo_fwdE, 64'h55); end
      tick();
      n_cmp++; if (hilo_o !== 64'h55) begin n_err++; $display("FAIL fm_hold: got %h want %h", hilo_o, 64'h55); end
   endtask

   task automatic test_reset_midflight();
      hilo_wenE = 1; aluoutE = 64'h77;
      tick();
      hilo_wenE = 0; aluoutE = '0;
      n_cmp++; if (hilo_busy !== 1'b1) begin n_err++; $display("FAIL rmf_busy_pre: got %b want 1", hilo_busy); end
      rst = 1'b0;
      #1;
      n_cmp++; if (hilo_o !== 64'h0) begin n_err++; $display("FAIL rmf_o: got %h want %h", hilo_o, 64'h0); end
      n_cmp++; if (hilo_fwdE !== 64'h0) begin n_err++; $display("FAIL rmf_fwd: got %h want %h", hilo_fwdE, 64'h0); end
      n_cmp++; if (hilo_busy !== 1'b0) begin n_err++; $display("FAIL rmf_busy: got %b want 0", hilo_busy); end
      tick();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (hilo_o !== 64'h0) begin n_err++; $display("FAIL rmf_after: got %h want %h", hilo_o, 64'h0); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_mthi();
      test_back_to_back();
      test_exception();
      test_stalls();
      test_flush_stall();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_hilo_pipe

// File: doc/hilo_pipe.md
Name: hilo_pipe

Overview:
- Owns the architectural HI/LO register pair and the E→M→W pipeline of pending HI/LO writes.
- Sits downstream of the execute-stage ALU: it consumes the ALU's 64-bit result, HI/LO write enable and HI/LO select.
- Commits the write at W, so an instruction killed by an exception in M never reaches HI/LO.
- Feeds the forwarded 64-bit HI/LO value back to the ALU's hilo input, and supplies the MFHI/MFLO read half.

Parameters:
- HILO_W, 64, width of the {HI,LO} pair; HI = upper half, LO = lower half.
- RST_HI, 32'h0, reset value of HI.
- RST_LO, 32'h0, reset value of LO.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallE  in  1  E stage held this cycle.
- stallM  in  1  M stage held.
- stallW  in  1  W stage held.
- flushM  in  1  kill the instruction moving E→M (M gets a bubble).
- flushW  in  1  kill the instruction moving M→W (exception in M).
- hilo_wenE  in  1  E instruction writes HI/LO.
- hilo_selectE  in  2  [1]=MFHI/MFLO instruction, [0]=1 read HI / 0 read LO.
- aluoutE  in  64  full new {HI,LO} value; MTHI/MTLO already merged.
- hilo_fwdE  out  64  forwarded {HI,LO} for the E stage.
- mfhilo_dataE  out  32  hilo_fwdE[63:32] if hilo_selectE[0] else [31:0]; 0 when hilo_selectE[1]=0.
- hilo_o  out  64  committed architectural {HI,LO}.
- hilo_busy  out  1  valid_m | valid_w (a write is in flight; debug/perf).

Behaviour:
- Reset (rst=0, async):
  - valid_m=0, valid_w=0, data_m=0, data_w=0.
  - hilo_r={RST_HI,RST_LO}.
  - Outputs therefore reset to hilo_o={RST_HI,RST_LO}, hilo_fwdE=same, hilo_busy=0.
  - Reset mid-pipeline discards all in-flight writes.
- E→M register, priority flushM > stallM > stallE:
  - flushM: valid_m←0.
  - else stallM: hold valid_m and data_m.
  - else stallE: valid_m←0 (bubble).
  - else: valid_m←hilo_wenE, data_m←aluoutE.
- M→W register, priority flushW > stallW > stallM:
  - flushW: valid_w←0.
  - else stallW: hold.
  - else stallM: valid_w←0.
  - else: valid_w←valid_m, data_w←data_m.
- Commit: if valid_w & ~stallW, then hilo_r←data_w at the edge. flushM/flushW never block a commit already in W.
- Forwarding (combinational), youngest first:
  - valid_m → data_m;
  - else valid_w → data_w;
  - else hilo_r.
- Latency:
  - Write visible on hilo_fwdE the cycle after it leaves E.
  - Write visible on hilo_o 3 edges after E with no stalls.
- Back-to-back writes: the M value shadows the W value. Both commit in order.
- Multi-cycle divide: the ALU raises hilo_wenE only in its ready cycle with stallE=0. Earlier stalled cycles insert no write.
- Simultaneous W commit and new E capture in one edge: both occur; no conflict.
- Widths: no arithmetic; data passes through unmodified.

Decomposition:
- Shared package/defines header: HI/LO select bit positions (SEL_MFHILO=1, SEL_HI=0) and reset constants.
- Natural sub-module: hilo_stage_reg, a valid+64-bit pipeline register with flush/stall/bubble inputs. Instantiate it twice (E→M, M→W).
- Commit register and forwarding mux stay in the top.

Test Plan:
- Reset: rst low mid-flight with valid_m=1 → hilo_o=0, hilo_fwdE=0, hilo_busy=0 immediately, without waiting for an edge.
- MTHI path: aluoutE=64'h12345678_00000000, hilo_wenE=1, no stalls → hilo_fwdE=that value 1 cycle later; hilo_o=that value after 3 edges; mfhilo_dataE with sel=2'b11 = 32'h12345678.
- Back-to-back: write A=64'h1 then B=64'h2 on consecutive cycles → hilo_fwdE shows 1 then 2; hilo_o ends at 64'h2 with no reversal.
- Exception: write 64'hDEAD in M with flushW=1 → never commits; hilo_o and hilo_fwdE revert to the previous value.
- Stalls: stallE=1 with hilo_wenE=1 for 5 cycles, then stallE=0 with value 64'hAB → exactly one commit of 64'hAB. stallW held 2 cycles → commit delayed 2 cycles, value unchanged.
- flushM with stallM both high → valid_m cleared (flush wins); a write in W still commits.
